// File: rtl/syndrome_accumulation_pkg.sv
// Shared definitions for the block-row syndrome accumulator: FSM encoding,
// default sizing and the beat-counter width helper.
package syndrome_accumulation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned DEF_M    = 4;
    localparam int unsigned DEF_NBLK = 3;
    localparam int unsigned DEF_CNTW = 16;

    // Width of a counter indexing beats 0..nblk-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned nblk);
        return (nblk <= 2) ? 1 : $clog2(nblk);
    endfunction

endpackage

// File: rtl/syndrome_acc_reg.sv
// M-lane XOR accumulator register: load overwrites, accumulate XORs in the new lane data.
module syndrome_acc_reg
    import syndrome_accumulation_pkg::*;
#(
    parameter int unsigned M = DEF_M
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         acc_i,
    input  logic [M-1:0] d_i,
    output logic [M-1:0] q_o
);

    logic [M-1:0] acc_q;
    logic [M-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = d_i;
        end else if (acc_i) begin
            acc_d = acc_q ^ d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign q_o = acc_q;

endmodule

// File: rtl/syndrome_accumulation.sv
// Block-row syndrome accumulator: XORs NBLK circulant partial products per word,
// presents the syndrome with a zero flag and counts nonzero results (saturating).
module syndrome_accumulation
    import syndrome_accumulation_pkg::*;
#(
    parameter int unsigned M    = DEF_M,
    parameter int unsigned NBLK = DEF_NBLK,
    parameter int unsigned CNTW = DEF_CNTW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [M-1:0]    in_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [M-1:0]    syndrome_o,
    output logic            syn_zero_o,
    output logic [CNTW-1:0] err_cnt_o,
    input  logic            err_clr_i,
    output logic [1:0]      state_o
);

    localparam int unsigned CW = cnt_width(NBLK);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBLK - 1);

    // Handshakes: a beat moves when in_valid_i & in_ready_o; a result moves when
    // out_valid_o & out_ready_i. Valid never waits on ready; flush_i overrides both.
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    syn_q, syn_d;
    logic            zero_q, zero_d;
    logic [CNTW-1:0] err_q, err_d;

    logic         beat;
    logic         beat_ok;
    logic         last_ok;
    logic         take;
    logic [M-1:0] acc;
    logic [M-1:0] acc_next;

    assign in_ready_o = (state_q != ST_DONE) | out_ready_i;
    assign beat       = in_valid_i & in_ready_o;
    assign beat_ok    = beat & ~flush_i;
    assign last_ok    = beat_ok & (cnt_q == LAST_BEAT);
    assign take       = (state_q == ST_DONE) & out_ready_i;
    assign acc_next   = acc ^ in_i;

    syndrome_acc_reg #(
        .M (M)
    ) u_acc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (beat_ok & (cnt_q == '0)),
        .acc_i  (beat_ok & (cnt_q != '0)),
        .d_i    (in_i),
        .q_o    (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beat) begin
                        state_d = ST_ACCUM;
                        cnt_d   = CW'(1);
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        if (cnt_q == LAST_BEAT) begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // A beat here is only possible while the result is being taken.
                    if (take) begin
                        if (beat) begin
                            state_d = ST_ACCUM;
                            cnt_d   = CW'(1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        syn_d  = syn_q;
        zero_d = zero_q;
        err_d  = err_q;
        if (last_ok) begin
            syn_d  = acc_next;
            zero_d = ~|acc_next;
        end
        if (err_clr_i) begin
            err_d = '0;
        end else if (last_ok && (|acc_next) && !(&err_q)) begin
            err_d = err_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            syn_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            syn_q   <= syn_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign out_valid_o = (state_q == ST_DONE);
    assign syndrome_o  = syn_q;
    assign syn_zero_o  = zero_q;
    assign err_cnt_o   = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_syndrome_accumulation.sv
// Directed bench for syndrome_accumulation (M=4, NBLK=3); a second instance with a
// 4-bit error counter exercises saturation on the same stimulus.
module tb_syndrome_accumulation;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [3:0]  in_i = '0;
  logic        out_ready_i = 1'b0;
  logic        err_clr_i = 1'b0;

  logic        in_ready_o, out_valid_o, syn_zero_o;
  logic [3:0]  syndrome_o;
  logic [15:0] err_cnt_o;
  logic [1:0]  state_o;

  logic        s_in_ready, s_out_valid, s_syn_zero;
  logic [3:0]  s_syndrome;
  logic [3:0]  s_err_cnt;
  logic [1:0]  s_state;

  int total = 0;
  int bad = 0;
  int exp_err = 0;
  int exp_err4 = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  syndrome_accumulation #(.M(4), .NBLK(3), .CNTW(16)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_i(in_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .syndrome_o(syndrome_o), .syn_zero_o(syn_zero_o),
    .err_cnt_o(err_cnt_o), .err_clr_i(err_clr_i), .state_o(state_o)
  );

  syndrome_accumulation #(.M(4), .NBLK(3), .CNTW(4)) u_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(s_in_ready), .in_i(in_i),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
    .syndrome_o(s_syndrome), .syn_zero_o(s_syn_zero),
    .err_cnt_o(s_err_cnt), .err_clr_i(err_clr_i), .state_o(s_state)
  );

  // scoreboard check
  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic count_nonzero(input logic [3:0] syn);
    if (syn != 4'h0) begin
      if (exp_err < 65535) exp_err++;
      if (exp_err4 < 15) exp_err4++;
    end
  endtask

  task automatic check_err(input string tag);
    check_val({tag, "_err"}, {16'h0, err_cnt_o}, exp_err);
    check_val({tag, "_err4"}, {28'h0, s_err_cnt}, exp_err4);
  endtask

  // driver: one beat, accepted on the next edge
  task automatic drive_beat(input string tag, input logic [3:0] d);
    in_valid_i = 1'b1;
    in_i = d;
    #1;
    check_val({tag, "_rdy"}, {31'h0, in_ready_o}, 32'h1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic drive_word(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] syn);
    drive_beat(tag, d0);
    drive_beat(tag, d1);
    drive_beat(tag, d2);
    count_nonzero(syn);
    check_val({tag, "_ov"}, {31'h0, out_valid_o}, 32'h1);
    check_val({tag, "_syn"}, {28'h0, syndrome_o}, {28'h0, syn});
    check_val({tag, "_zero"}, {31'h0, syn_zero_o}, {31'h0, (syn == 4'h0)});
    check_err(tag);
  endtask

  initial begin
    // reset state
    #3;
    check_val("rst_ov", {31'h0, out_valid_o}, 32'h0);
    check_val("rst_rdy", {31'h0, in_ready_o}, 32'h1);
    check_val("rst_zero", {31'h0, syn_zero_o}, 32'h0);
    check_val("rst_syn", {28'h0, syndrome_o}, 32'h0);
    check_val("rst_state", {30'h0, state_o}, 32'h0);
    check_err("rst");
    tick();
    rst_ni = 1'b1;
    tick();

    // 1: zero syndrome, back-to-back
    out_ready_i = 1'b1;
    drive_word("t1", 4'b1010, 4'b0110, 4'b1100, 4'b0000);
    tick();
    check_val("t1_ov_drop", {31'h0, out_valid_o}, 32'h0);
    check_val("t1_syn_hold", {28'h0, syndrome_o}, 32'h0);
    check_val("t1_zero_hold", {31'h0, syn_zero_o}, 32'h1);

    // 2: result held under backpressure
    out_ready_i = 1'b0;
    drive_word("t2", 4'b0001, 4'b0010, 4'b0100, 4'b0111);
    for (int i = 0; i < 5; i++) begin
      check_val("t2_hold_ov", {31'h0, out_valid_o}, 32'h1);
      check_val("t2_hold_syn", {28'h0, syndrome_o}, 32'h7);
      check_val("t2_hold_zero", {31'h0, syn_zero_o}, 32'h0);
      check_val("t2_hold_rdy", {31'h0, in_ready_o}, 32'h0);
      tick();
    end

    // 3: hand-off overlapped with beat 0 of next word
    out_ready_i = 1'b1;
    drive_beat("t3", 4'b1111);
    check_val("t3_ov_taken", {31'h0, out_valid_o}, 32'h0);
    check_val("t3_state", {30'h0, state_o}, 32'h1);
    drive_beat("t3", 4'b1111);
    drive_beat("t3", 4'b0011);
    count_nonzero(4'b0011);
    check_val("t3_ov", {31'h0, out_valid_o}, 32'h1);
    check_val("t3_syn", {28'h0, syndrome_o}, 32'h3);
    check_err("t3");
    tick();

    // 4: flush mid-word, same-cycle beat dropped
    drive_beat("t4", 4'b1010);
    drive_beat("t4", 4'b0101);
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    in_i = 4'b1111;
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check_val("t4_state", {30'h0, state_o}, 32'h0);
    check_val("t4_ov", {31'h0, out_valid_o}, 32'h0);
    drive_word("t4", 4'b1000, 4'b0100, 4'b0010, 4'b1110);
    tick();
    // flush discards a pending result but keeps err_cnt
    out_ready_i = 1'b0;
    drive_word("t4p", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("t4p_ov", {31'h0, out_valid_o}, 32'h0);
    check_val("t4p_rdy", {31'h0, in_ready_o}, 32'h1);
    check_err("t4p");

    // 5: async reset mid-word
    out_ready_i = 1'b1;
    drive_beat("t5", 4'b0110);
    #2 rst_ni = 1'b0;
    #1;
    exp_err = 0;
    exp_err4 = 0;
    check_val("t5_ov", {31'h0, out_valid_o}, 32'h0);
    check_val("t5_rdy", {31'h0, in_ready_o}, 32'h1);
    check_val("t5_state", {30'h0, state_o}, 32'h0);
    check_err("t5");
    #1 rst_ni = 1'b1;
    tick();
    drive_word("t5w", 4'b0011, 4'b0101, 4'b1000, 4'b1110);

    // 6: saturation on the narrow counter, then err_clr beats an increment
    for (int i = 0; i < 15; i++) begin
      drive_word("t6", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    end
    check_val("t6_sat4", {28'h0, s_err_cnt}, 32'hF);
    check_val("t6_wide", {16'h0, err_cnt_o}, 32'd16);
    drive_beat("t6c", 4'b0100);
    drive_beat("t6c", 4'b0000);
    err_clr_i = 1'b1;
    drive_beat("t6c", 4'b0000);
    err_clr_i = 1'b0;
    exp_err = 0;
    exp_err4 = 0;
    check_val("t6c_syn", {28'h0, syndrome_o}, 32'h4);
    check_err("t6c");
    drive_word("t6r", 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
